clint: RTL
==========

# clint

Core-local interruptor for a single hart. It holds the memory-mapped `msip`, `mtimecmp` and `mtime` registers and serves them over a simple request/response port from the data-memory path. It drives the CSR unit's `in_time` input and the MSIP/MTIP bits of its `in_ip` input. `mtime` advances once every `DIV` clock cycles.

## Interface
- `DIV`, default 1: clk cycles per `mtime` increment; legal range 1..65535.
- `clk`: input, 1, clock.
- `rst`: input, 1, reset, synchronous, active-high.
- `req_vld`: input, 1, request valid.
- `req_rdy`: output, 1, request accepted when `req_vld & req_rdy`.
- `req_we`: input, 1, 1 = write, 0 = read.
- `req_addr`: input, 16, byte offset inside the CLINT window; `[2:0]` ignored.
- `req_wdat`: input, 64, write data, aligned to the 8-byte word.
- `req_wstb`: input, 8, byte write strobes.
- `rsp_vld`: output, 1, response valid.
- `rsp_rdy`: input, 1, response consumed when `rsp_vld & rsp_rdy`.
- `rsp_dat`: output, 64, read data (0 for writes and errors).
- `rsp_err`: output, 1, access to an unmapped offset.
- `out_time`: output, 64, current `mtime`, to the CSR unit's `in_time`.
- `out_ip`: output, 64, interrupt pending to the CSR unit's `in_ip`. Bit 3 = MSIP, bit 7 = MTIP, all other bits 0.

## Operation
- Register map, 8-byte word offsets, other offsets unmapped:
  - 0x0000 `msip`: only bit 0 is implemented; all other bits read 0 and ignore writes.
  - 0x4000 `mtimecmp`: 64-bit.
  - 0xbff8 `mtime`: 64-bit.
- Writes merge per byte: `new[8i+7:8i] = wstb[i] ? wdat[8i+7:8i] : old[8i+7:8i]`.
- Reads return the register value at acceptance time.
  - An `mtime` read returns the value before any increment in that cycle.
- Unmapped offset: `rsp_err = 1`, `rsp_dat = 0`, no state change.
- Prescaler: counter `pcnt`, width 16.
  - Each cycle: if `pcnt == DIV-1`, then `pcnt <= 0` and tick; else `pcnt <= pcnt+1`.
  - Tick: `mtime <= mtime + 1`, modulo 2^64; `0xffff_ffff_ffff_ffff` wraps to 0.
- Accepted write to `mtime` in the same cycle as a tick: the write wins, there is no increment that cycle, and `pcnt` still advances/wraps normally.
- MTIP register: `mtip <= (mtime >= mtimecmp)`, unsigned compare on the current register values, evaluated every cycle.
- MSIP: `out_ip[3] = msip[0]`, driven straight from the register.
- Handshake state machine, states IDLE and RESP:
  - IDLE: `req_rdy = 1`, `rsp_vld = 0`. On `req_vld`, the access is performed and the state goes to RESP.
  - RESP: `rsp_vld = 1`; `rsp_dat`/`rsp_err` are held stable.
    - `req_rdy = rsp_rdy`, so back-to-back accesses are possible.
    - On `rsp_rdy & req_vld`: the new access is performed and the state stays RESP.
    - On `rsp_rdy & ~req_vld`: go to IDLE.
    - On `~rsp_rdy`: stay in RESP; the request is not accepted.
- Reset:
  - `mtime = 0`, `mtimecmp = 64'hffff_ffff_ffff_ffff`, `msip = 0`, `mtip = 0`, `pcnt = 0`, state IDLE.
  - Outputs: `out_time = 0`, `out_ip = 0`, `rsp_vld = 0`, `rsp_dat = 0`, `rsp_err = 0`, `req_rdy = 1` from the first cycle after reset.
  - Reset during RESP drops the pending response; it is never delivered.

## Timing
- Access latency: a request accepted at edge n gives `rsp_vld` high after edge n, visible in cycle n+1.
  - Throughput is 1 access/cycle while `rsp_rdy = 1`.
- A write takes effect at the accepting edge; a read in the following cycle sees the new value.
- `out_time` is combinational from the `mtime` register, so it changes at the tick edge.
- MTIP delay:
  - `out_ip[7]` rises one cycle after `mtime >= mtimecmp` first holds in the registers.
  - It falls one cycle after a write makes `mtimecmp > mtime`, or after `mtime` wraps.
- `out_ip[3]` changes at the edge that accepts the `msip` write.

## Test plan
- Reset, `DIV=1`, 20 idle cycles -> `out_time` counts 0..20, `out_ip = 0`, `rsp_vld = 0`, `req_rdy = 1`.
- `DIV=4`: write `mtimecmp = 5` -> `out_ip[7]` rises exactly 1 cycle after `out_time` reaches 5. Then write `mtimecmp = 100` -> `out_ip[7] = 0` two cycles after acceptance.
- Write `msip = 0xffff_ffff` with `wstb = 0x0f` -> `out_ip = 0x8`, read back gives 1. Write 0 -> `out_ip[3] = 0` after the accepting edge.
- Write `mtime = 0xffff_ffff_ffff_fffe`, `DIV=1` -> `out_time` goes ...fffe, ...ffff, 0, 1. Any MTIP set by the high values clears after the wrap.
- Partial write `wstb = 0xf0`, `wdat = 0x1234_5678_0000_0000` to `mtimecmp` (reset value all ones) -> read back `0x1234_5678_ffff_ffff`. Unmapped read at 0x1000 -> `rsp_err = 1`, `rsp_dat = 0`.
- Hold `rsp_rdy = 0` for 3 cycles with `req_vld = 1` -> `req_rdy = 0` and `rsp_dat` stable. Release -> the next request is accepted the same edge. `rst` asserted in RESP -> `rsp_vld = 0` next cycle.

Source files
------------

// File: rtl/clint.sv
// clint: core-local interruptor holding msip, mtimecmp and mtime behind a request/response port
module clint #(
  parameter int unsigned DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_vld,
  output logic        req_rdy,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [63:0] req_wdat,
  input  logic [7:0]  req_wstb,
  output logic        rsp_vld,
  input  logic        rsp_rdy,
  output logic [63:0] rsp_dat,
  output logic        rsp_err,
  output logic [63:0] out_time,
  output logic [63:0] out_ip
);
  typedef enum logic {IDLE, RESP} state_t;
  localparam logic [15:0] PMAX = 16'(DIV - 1);
  state_t state, state_n;
  logic [63:0] mtime, mtimecmp, rd;
  logic [15:0] pcnt;
  logic [12:0] word;
  logic msip, mtip, acc, tick, sel_msip, sel_cmp, sel_time, hit, wr;
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] st);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i+:8] = st[i] ? wd[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
  assign word     = req_addr[15:3];
  assign sel_msip = word == 13'h0000;
  assign sel_cmp  = word == 13'h0800;
  assign sel_time = word == 13'h17ff;
  assign hit      = sel_msip | sel_cmp | sel_time;
  assign tick     = pcnt == PMAX;
  assign wr       = acc & req_we;
  assign rd       = sel_msip ? {63'd0, msip} : sel_cmp ? mtimecmp : sel_time ? mtime : 64'd0;
  assign out_time = mtime;
  assign out_ip   = {56'd0, mtip, 3'd0, msip, 3'd0};
  // handshake state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  // handshake next state and ready/valid; a held response blocks new requests
  always_comb begin
    rsp_vld = state == RESP;
    req_rdy = state == IDLE || rsp_rdy;
    acc     = req_vld && req_rdy;
    state_n = acc ? RESP : rsp_rdy ? IDLE : state;
  end
  // response capture at the accepting edge, held until the next acceptance
  always_ff @(posedge clk)
    if (rst) begin
      rsp_dat <= 64'd0;
      rsp_err <= 1'b0;
    end else if (acc) begin
      rsp_dat <= (req_we || !hit) ? 64'd0 : rd;
      rsp_err <= !hit;
    end
  // prescaler and timer; a software write to mtime overrides that cycle's tick
  always_ff @(posedge clk)
    if (rst) begin
      pcnt  <= 16'd0;
      mtime <= 64'd0;
    end else begin
      pcnt  <= tick ? 16'd0 : pcnt + 16'd1;
      mtime <= (wr && sel_time) ? merge(mtime, req_wdat, req_wstb) : tick ? mtime + 64'd1 : mtime;
    end
  // software-writable compare and msip registers, plus the registered timer compare
  always_ff @(posedge clk)
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
      mtip     <= 1'b0;
    end else begin
      mtip     <= mtime >= mtimecmp;
      mtimecmp <= (wr && sel_cmp) ? merge(mtimecmp, req_wdat, req_wstb) : mtimecmp;
      msip     <= (wr && sel_msip && req_wstb[0]) ? req_wdat[0] : msip;
    end
endmodule
